// File: rtl/par_frame_pkg.sv
// Shared types for the parity-framed serial transmitter: tracker and FSM encodings,
// the preamble pattern and the trailer-select helper.
package par_frame_pkg;

  // First letter: zero-count parity, second letter: one-count parity (same as the detector).
  typedef enum logic [1:0] {
    TRK_EE = 2'd0,
    TRK_OE = 2'd1,
    TRK_EO = 2'd2,
    TRK_OO = 2'd3
  } trk_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_DATA = 3'd2,
    S_TRL0 = 3'd3,
    S_TRL1 = 3'd4
  } state_t;

  localparam logic [1:0] PREAMBLE = 2'b11;

  function automatic trk_t trk_step(input trk_t t, input logic b);
    logic [1:0] v;
    v = t;
    if (b) v[1] = ~v[1];
    else   v[0] = ~v[0];
    return trk_t'(v);
  endfunction

  // Tracker value after TRL0 is OE or EO; pick the bit that lands in OO.
  function automatic logic trl_sel(input trk_t t);
    return (t == TRK_OE);
  endfunction

endpackage

// File: rtl/par_tracker.sv
// Two-bit zero/one parity tracker; clear has priority over a counted bit.
module par_tracker
  import par_frame_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic en,
  input  logic bit_in,
  output trk_t trk,
  output trk_t trk_next
);

  always_comb begin
    trk_next = trk;
    if (clear)   trk_next = TRK_EE;
    else if (en) trk_next = trk_step(trk, bit_in);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) trk <= TRK_EE;
    else          trk <= trk_next;
  end

endmodule

// File: rtl/par_frame_tx.sv
// Parity-framed serial transmitter: parallel word in over valid/ready, MSB-first bits out
// plus two trailer bits. Optional two-bit preamble under `PAR_FRAME_TX_PREAMBLE_EN.
module par_frame_tx
  import par_frame_pkg::*;
#(
  parameter int DATA_W = 8
)
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              dout,
  output logic              dout_valid,
  output logic              busy,
  output logic              frame_done,
  output state_t            state_dbg
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  if ((DATA_W % 2) != 0 || DATA_W < 2) begin : g_bad_width
    $error("par_frame_tx: DATA_W must be even and at least 2");
  end

  state_t              state, state_d;
  logic [DATA_W-1:0]   shift, shift_d;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic                dout_d, dout_valid_d, frame_done_d, busy_d;
  logic                accept;
  trk_t                trk_q, trk_next;

  // Handshake: a word transfers on a rising edge where din_valid && din_ready;
  // din_ready is high only in IDLE, so din is never sampled mid-frame.
  assign din_ready = (state == S_IDLE);
  assign accept    = din_ready && din_valid;
  assign state_dbg = state;

  // Tracker follows the registered output stream, so it counts bits as they are shown.
  par_tracker u_tracker (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (accept),
    .en       (dout_valid),
    .bit_in   (dout),
    .trk      (trk_q),
    .trk_next (trk_next)
  );

  always_comb begin
    state_d      = state;
    shift_d      = shift;
    cnt_d        = cnt;
    dout_d       = 1'b0;
    dout_valid_d = 1'b0;
    frame_done_d = 1'b0;
    case (state)
      S_IDLE: begin
        if (din_valid) begin
          dout_valid_d = 1'b1;
`ifdef PAR_FRAME_TX_PREAMBLE_EN
          state_d = S_PRE;
          dout_d  = PREAMBLE[1];
          shift_d = din;
          cnt_d   = '0;
`else
          state_d = S_DATA;
          dout_d  = din[DATA_W-1];
          shift_d = din << 1;
          cnt_d   = CNT_W'(1);
`endif
        end
      end
`ifdef PAR_FRAME_TX_PREAMBLE_EN
      // cnt doubles as the preamble position before the payload starts.
      S_PRE: begin
        dout_valid_d = 1'b1;
        if (cnt == '0) begin
          dout_d = PREAMBLE[0];
          cnt_d  = CNT_W'(1);
        end else begin
          state_d = S_DATA;
          dout_d  = shift[DATA_W-1];
          shift_d = shift << 1;
          cnt_d   = CNT_W'(1);
        end
      end
`endif
      S_DATA: begin
        dout_valid_d = 1'b1;
        if (cnt == CNT_W'(DATA_W)) begin
          state_d = S_TRL0;
          dout_d  = 1'b0;
        end else begin
          dout_d  = shift[DATA_W-1];
          shift_d = shift << 1;
          cnt_d   = cnt + CNT_W'(1);
        end
      end
      S_TRL0: begin
        state_d      = S_TRL1;
        dout_d       = trl_sel(trk_next);
        dout_valid_d = 1'b1;
        frame_done_d = 1'b1;
      end
      S_TRL1: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      shift      <= '0;
      cnt        <= '0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      shift      <= shift_d;
      cnt        <= cnt_d;
      dout       <= dout_d;
      dout_valid <= dout_valid_d;
      frame_done <= frame_done_d;
      busy       <= busy_d;
    end
  end

  // Every completed frame must leave the tracker in OO; between frames only EE/OO are legal.
  always @(posedge clk) begin
    if (reset_n && state == S_TRL1) assert (trk_next == TRK_OO);
    if (reset_n && state == S_IDLE) assert (trk_q == TRK_EE || trk_q == TRK_OO);
  end

endmodule

// File: tb/tb_par_frame_tx.sv
// Bench for par_frame_tx: scoreboard of expected {frame_done, dout} pairs checked on every negedge.
module tb_par_frame_tx;
  import par_frame_pkg::*;

  localparam int DATA_W = 8;
`ifdef PAR_FRAME_TX_PREAMBLE_EN
  localparam int PRE_LEN = 2;
`else
  localparam int PRE_LEN = 0;
`endif
  localparam int FRAME_LEN = PRE_LEN + DATA_W + 2;
  localparam int PERIOD    = FRAME_LEN + 1;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [DATA_W-1:0] din = '0;
  logic              din_valid = 1'b0;
  logic              din_ready, dout, dout_valid, busy, frame_done;
  state_t            state_dbg;
  trk_t              gold_trk, gold_next;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int frame_cnt = 0;
  int last_done = -1;
  bit check_gap = 1'b0;
  logic [1:0] exp_q[$];

  par_frame_tx #(.DATA_W(DATA_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .frame_done (frame_done),
    .state_dbg  (state_dbg)
  );

  par_tracker u_gold (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (~dout_valid),
    .en       (dout_valid),
    .bit_in   (dout),
    .trk      (gold_trk),
    .trk_next (gold_next)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [1:0] e;
    cyc++;
    if (dout_valid === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_bit: dout=%b frame_done=%b at cycle %0d, required no frame bit", dout, frame_done, cyc);
      end else begin
        e = exp_q.pop_front();
        if (dout !== e[0] || frame_done !== e[1]) begin
          n_err++;
          $display("FAIL frame_bit: dout=%b frame_done=%b at cycle %0d, required dout=%b frame_done=%b", dout, frame_done, cyc, e[0], e[1]);
        end
      end
      if (frame_done === 1'b1) begin
        frame_cnt++;
        n_vec++;
        if (gold_next !== TRK_OO) begin
          n_err++;
          $display("FAIL golden_tracker: %0d at frame_done, required %0d", gold_next, TRK_OO);
        end
        if (check_gap && last_done >= 0) begin
          n_vec++;
          if (cyc - last_done != PERIOD) begin
            n_err++;
            $display("FAIL frame_gap: %0d cycles, required %0d", cyc - last_done, PERIOD);
          end
        end
        last_done = cyc;
      end
    end else begin
      n_vec++;
      if (frame_done !== 1'b0) begin
        n_err++;
        $display("FAIL spurious_done: frame_done=%b with dout_valid=0, required 0", frame_done);
      end
    end
  end

  task automatic push_frame(input logic [DATA_W-1:0] v);
    int ones;
    ones = 0;
    for (int i = 0; i < PRE_LEN; i++) begin
      exp_q.push_back(2'b01);
      ones++;
    end
    for (int i = DATA_W - 1; i >= 0; i--) begin
      exp_q.push_back({1'b0, v[i]});
      if (v[i]) ones++;
    end
    exp_q.push_back(2'b00);
    exp_q.push_back({1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0});
  endtask

  // Drives one word at a negedge once ready; returns at the negedge showing its first bit.
  task automatic offer(input logic [DATA_W-1:0] v);
    int w;
    w = 0;
    while (din_ready !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    n_vec++;
    if (din_ready !== 1'b1) begin
      n_err++;
      $display("FAIL ready_timeout: din_ready=%b after %0d cycles, required 1", din_ready, w);
    end else begin
      din       = v;
      din_valid = 1'b1;
      push_frame(v);
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || dout_valid !== 1'b0) && w < 200) begin
      @(negedge clk);
      w++;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d frame bits still pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({dout, dout_valid, busy, frame_done} !== 4'b0000 || gold_trk !== TRK_EE) begin
      n_err++;
      $display("FAIL reset_outputs: dout/valid/busy/done=%b trk=%0d, required 0000 trk=0", {dout, dout_valid, busy, frame_done}, gold_trk);
    end
    reset_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (din_ready !== 1'b1 || state_dbg !== S_IDLE) begin
      n_err++;
      $display("FAIL reset_idle: din_ready=%b state=%0d, required 1 and %0d", din_ready, state_dbg, S_IDLE);
    end
  endtask

  task automatic test_single_a5();
    offer(8'hA5);
    din_valid = 1'b0;
    for (int i = 0; i < FRAME_LEN; i++) begin
      n_vec++;
      if ({dout_valid, din_ready, busy, frame_done} !== {1'b1, 1'b0, 1'b1, (i == FRAME_LEN - 1)}) begin
        n_err++;
        $display("FAIL a5_timing: bit %0d valid/ready/busy/done=%b, required %b", i, {dout_valid, din_ready, busy, frame_done}, {1'b1, 1'b0, 1'b1, (i == FRAME_LEN - 1)});
      end
      @(negedge clk);
    end
    n_vec++;
    if ({din_ready, busy, dout_valid} !== 3'b100) begin
      n_err++;
      $display("FAIL a5_after: ready/busy/valid=%b, required 100", {din_ready, busy, dout_valid});
    end
    drain();
  endtask

  task automatic test_trailers();
    offer(8'h01);
    din_valid = 1'b0;
    drain();
    offer(8'h00);
    din_valid = 1'b0;
    drain();
    offer(8'hFF);
    din_valid = 1'b0;
    drain();
    offer(DATA_W'($urandom_range(0, 255)));
    din_valid = 1'b0;
    drain();
  endtask

  task automatic test_back_to_back();
    int start;
    start     = frame_cnt;
    last_done = -1;
    check_gap = 1'b1;
    for (int v = 0; v < 256; v++) offer(DATA_W'(v));
    din_valid = 1'b0;
    drain();
    check_gap = 1'b0;
    n_vec++;
    if (frame_cnt - start != 256) begin
      n_err++;
      $display("FAIL b2b_frames: %0d frames, required 256", frame_cnt - start);
    end
  endtask

  task automatic test_reset_mid_frame();
    int start;
    offer(8'hFF);
    din_valid = 1'b0;
    repeat (PRE_LEN + 3) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    n_vec++;
    if ({dout, dout_valid, busy, frame_done} !== 4'b0000) begin
      n_err++;
      $display("FAIL abort_outputs: dout/valid/busy/done=%b, required 0000", {dout, dout_valid, busy, frame_done});
    end
    exp_q.delete();
    start = frame_cnt;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (din_ready !== 1'b1) begin
      n_err++;
      $display("FAIL abort_ready: din_ready=%b, required 1", din_ready);
    end
    offer(8'h3C);
    din_valid = 1'b0;
    drain();
    n_vec++;
    if (frame_cnt - start != 1) begin
      n_err++;
      $display("FAIL abort_frames: %0d frames after abort, required 1", frame_cnt - start);
    end
  endtask

  initial begin
    test_reset();
    test_single_a5();
    test_trailers();
    test_back_to_back();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
